// File: rtl/final2_soc_otg_hpi_int_in.sv
// Avalon-MM parallel input port: synchronizer, per-bit glitch filter,
// edge capture with write-1-to-clear, and a masked level interrupt.
module final2_soc_otg_hpi_int_in #(
  parameter int WIDTH         = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [7:0]       r_cnt [WIDTH];
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;
  logic             w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_clr    = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // The filtered bit follows the synchronized bit only after it has differed
  // for FILTER_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= '0;
      r_prev <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 8'd0;
    end else begin
      r_prev <= r_filt;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0)      w_edge = r_filt & ~r_prev;
    else if (EDGE_TYPE == 1) w_edge = ~r_filt & r_prev;
    else                     w_edge = r_filt ^ r_prev;
  end

  // A new edge outranks a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
      r_cap <= (r_cap & ~w_clr) | w_edge;
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (address)
      2'd0:    w_rdmux[WIDTH-1:0] = r_filt;
      2'd2:    w_rdmux[WIDTH-1:0] = r_mask;
      2'd3:    w_rdmux[WIDTH-1:0] = r_cap;
      default: w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rdmux;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_final2_soc_otg_hpi_int_in.sv
// Randomized and directed bench for the filtered Avalon input port, checked
// against a sliding-window reference model of the filter and register map.
module tb_final2_soc_otg_hpi_int_in;
  localparam int WIDTH = 2;
  localparam int FC    = 4;
  localparam int ET    = 0;

  logic             clk;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int nCompared;
  int nMismatched;

  // reference model state
  logic [WIDTH-1:0] mS1, mS2, mFilt, mPrev, mMask, mCap;
  logic [31:0]      mRead;
  logic [WIDTH-1:0] syncHist[$];

  final2_soc_otg_hpi_int_in #(.WIDTH(WIDTH), .FILTER_CYCLES(FC), .EDGE_TYPE(ET)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    mS1 = '0; mS2 = '0; mFilt = '0; mPrev = '0; mMask = '0; mCap = '0;
    mRead = '0;
    syncHist.delete();
  endfunction

  // The filtered bit flips once the last FC synchronized samples all disagree with it.
  function automatic void modelStep(logic [WIDTH-1:0] inp, logic cs, logic wn,
                                    logic [1:0] addr, logic [31:0] wd);
    logic [31:0]      rd;
    logic [WIDTH-1:0] edges, clr, nextFilt;
    logic             wr, allDiff;
    rd = '0;
    case (addr)
      2'd0: rd[WIDTH-1:0] = mFilt;
      2'd2: rd[WIDTH-1:0] = mMask;
      2'd3: rd[WIDTH-1:0] = mCap;
      default: rd = '0;
    endcase
    if (ET == 0)      edges = mFilt & ~mPrev;
    else if (ET == 1) edges = ~mFilt & mPrev;
    else              edges = mFilt ^ mPrev;
    wr  = cs && !wn;
    clr = (wr && addr == 2'd3) ? wd[WIDTH-1:0] : '0;
    if (wr && addr == 2'd2) mMask = wd[WIDTH-1:0];
    mCap  = (mCap & ~clr) | edges;
    mPrev = mFilt;
    syncHist.push_back(mS2);
    if (syncHist.size() > FC) void'(syncHist.pop_front());
    nextFilt = mFilt;
    if (syncHist.size() == FC) begin
      for (int b = 0; b < WIDTH; b++) begin
        allDiff = 1'b1;
        foreach (syncHist[k]) if (syncHist[k][b] == mFilt[b]) allDiff = 1'b0;
        if (allDiff) nextFilt[b] = ~mFilt[b];
      end
    end
    mFilt = nextFilt;
    mS2   = mS1;
    mS1   = inp;
    mRead = rd;
  endfunction

  task automatic tick();
    logic [WIDTH-1:0] inp;
    logic             cs, wn, rst;
    logic [1:0]       addr;
    logic [31:0]      wd;
    inp = in_port; cs = chipselect; wn = write_n; addr = address; wd = writedata;
    rst = reset;
    @(posedge clk);
    if (rst) modelReset();
    else     modelStep(inp, cs, wn, addr, wd);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic busIdle();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    busIdle();
  endtask

  task automatic busRead(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a; writedata = '0;
    tick();
    busIdle();
  endtask

  task automatic doReset(input logic [WIDTH-1:0] inp);
    busIdle();
    in_port = inp;
    reset = 1'b1;
    modelReset();
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset('0);
    nCompared++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state readdata=%h irq=%b required 0/0", readdata, irq);
    end
    for (int a = 0; a < 4; a++) begin
      busRead(2'(a));
      nCompared++;
      if (readdata !== 32'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset_read addr=%0d got=%h required=0", a, readdata);
      end
    end
  endtask

  task automatic test_rising();
    doReset('0);
    busWrite(2'd2, 32'h1);
    in_port = 2'b01;
    ticks(6);
    nCompared++;
    if (irq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rising_irq_early got=%b required=0", irq);
    end
    tick();
    nCompared++;
    if (irq !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rising_irq_at7 got=%b required=1", irq);
    end
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h1 || readdata !== mRead) begin
      nMismatched++;
      $display("[TB] FAIL rising_edgecapture got=%h required=1 model=%h", readdata, mRead);
    end
    busRead(2'd0);
    nCompared++;
    if (readdata !== 32'h1) begin
      nMismatched++;
      $display("[TB] FAIL rising_data got=%h required=1", readdata);
    end
  endtask

  task automatic test_glitch();
    doReset('0);
    busWrite(2'd2, 32'h3);
    in_port = 2'b10;
    ticks(3);
    in_port = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      nCompared++;
      if (irq !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL glitch_irq cycle=%0d got=%b required=0", i, irq);
      end
    end
    busRead(2'd0);
    nCompared++;
    if (readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_data got=%h required=0", readdata);
    end
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_edgecapture got=%h required=0", readdata);
    end
  endtask

  task automatic test_clear();
    doReset('0);
    busWrite(2'd2, 32'h3);
    in_port = 2'b11;
    ticks(10);
    busWrite(2'd3, 32'h1);
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h2) begin
      nMismatched++;
      $display("[TB] FAIL clear_edgecapture got=%h required=2", readdata);
    end
    nCompared++;
    if (irq !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL clear_irq_mask3 got=%b required=1", irq);
    end
    busWrite(2'd2, 32'h1);
    nCompared++;
    if (irq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL clear_irq_mask1 got=%b required=0", irq);
    end
  endtask

  task automatic test_collision();
    doReset('0);
    busWrite(2'd2, 32'h1);
    in_port = 2'b01;
    ticks(6);
    busWrite(2'd3, 32'h1);
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h1 || readdata !== mRead) begin
      nMismatched++;
      $display("[TB] FAIL collision_set_wins got=%h required=1", readdata);
    end
    busWrite(2'd3, 32'h1);
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL collision_later_clear got=%h required=0", readdata);
    end
  endtask

  task automatic test_mask();
    doReset('0);
    in_port = 2'b10;
    ticks(10);
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h2 || irq !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mask_gated cap=%h irq=%b required 2/0", readdata, irq);
    end
    busWrite(2'd2, 32'h2);
    nCompared++;
    if (irq !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL mask_unmask_irq got=%b required=1", irq);
    end
    busWrite(2'd0, 32'h3);
    busWrite(2'd1, 32'h3);
    busRead(2'd1);
    nCompared++;
    if (readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reserved_read got=%h required=0", readdata);
    end
    busRead(2'd3);
    nCompared++;
    if (readdata !== 32'h2) begin
      nMismatched++;
      $display("[TB] FAIL ignored_writes cap=%h required=2", readdata);
    end
  endtask

  task automatic test_async_reset();
    doReset('0);
    busWrite(2'd2, 32'h3);
    in_port = 2'b11;
    ticks(10);
    in_port = 2'b00;
    ticks(4);
    address = 2'd3;
    tick();
    nCompared++;
    if (irq !== 1'b1 || readdata !== 32'h3) begin
      nMismatched++;
      $display("[TB] FAIL async_setup irq=%b cap=%h required 1/3", irq, readdata);
    end
    reset = 1'b1;
    modelReset();
    #2;
    nCompared++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_immediate irq=%b readdata=%h required 0/0", irq, readdata);
    end
    ticks(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      busRead(2'(a));
      nCompared++;
      if (readdata !== 32'h0) begin
        nMismatched++;
        $display("[TB] FAIL async_reset_regs addr=%0d got=%h required=0", a, readdata);
      end
    end
  endtask

  task automatic test_release_high();
    doReset(2'b11);
    address = 2'd3;
    ticks(7);
    nCompared++;
    if (readdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL release_high_early got=%h required=0", readdata);
    end
    tick();
    nCompared++;
    if (readdata !== 32'h3 || readdata !== mRead) begin
      nMismatched++;
      $display("[TB] FAIL release_high_capture got=%h required=3", readdata);
    end
    busIdle();
  endtask

  task automatic test_random();
    int hold;
    doReset('0);
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        in_port = WIDTH'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 4) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
      nCompared++;
      if (readdata !== mRead || irq !== |(mCap & mMask)) begin
        nMismatched++;
        $display("[TB] FAIL random cycle=%0d readdata=%h irq=%b required %h/%b",
                 i, readdata, irq, mRead, |(mCap & mMask));
      end
    end
    busIdle();
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    reset = 1'b1;
    in_port = '0;
    busIdle();
    modelReset();
    #1;
    test_reset();
    test_rising();
    test_glitch();
    test_clear();
    test_collision();
    test_mask();
    test_async_reset();
    test_release_high();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
